// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
package regfile_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_A0   = 10;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, write-back clears, set wins; index 0 never pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_en,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  input  logic                           wb0_en,
  input  logic [ADDR_WIDTH-1:0]          wb0_rd,
  input  logic                           wb1_en,
  input  logic [ADDR_WIDTH-1:0]          wb1_rd,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ-1:0]            rd_pending
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] pending_next;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_en) set_vec[issue_rd] = 1'b1;
    if (wb0_en)   clr_vec[wb0_rd]   = 1'b1;
    if (wb1_en)   clr_vec[wb1_rd]   = 1'b1;
    // OR-ing the set after the clear lets a new producer supersede the retiring one
    pending_next    = (pending & ~clr_vec) | set_vec;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  for (genvar g = 0; g < NUM_READ; g++) begin : g_lookup
    logic [ADDR_WIDTH-1:0] addr;
    assign addr          = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_pending[g] = (addr == ADDR_WIDTH'(REG_ZERO)) ? 1'b0 : pending[addr];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual write-back register file with pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic                           issue_en,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  input  logic                           wb0_en,
  input  logic [ADDR_WIDTH-1:0]          wb0_rd,
  input  logic [DATA_WIDTH-1:0]          wb0_data,
  input  logic                           wb1_en,
  input  logic [ADDR_WIDTH-1:0]          wb1_rd,
  input  logic [DATA_WIDTH-1:0]          wb1_data,
  output logic [DATA_WIDTH-1:0]          a0
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [NUM_READ-1:0]   rd_pending;

  // WB1 is written last so it wins on a same-index collision
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else begin
      if (wb0_en && wb0_rd != IDX_ZERO) regs[wb0_rd] <= wb0_data;
      if (wb1_en && wb1_rd != IDX_ZERO) regs[wb1_rd] <= wb1_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .wb0_en     (wb0_en),
    .wb0_rd     (wb0_rd),
    .wb1_en     (wb1_en),
    .wb1_rd     (wb1_rd),
    .rd_addr    (rd_addr),
    .rd_pending (rd_pending)
  );

  for (genvar g = 0; g < NUM_READ; g++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;

    assign addr = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data = (addr == IDX_ZERO) ? '0 : regs[addr];
      busy = rd_pending[g];
`ifdef REGFILE_BYPASS_EN
      if (addr != IDX_ZERO) begin
        if (wb1_en && wb1_rd == addr)      data = wb1_data;
        else if (wb0_en && wb0_rd == addr) data = wb0_data;
        if (((wb0_en && wb0_rd == addr) || (wb1_en && wb1_rd == addr)) &&
            !(issue_en && issue_rd == addr))
          busy = 1'b0;
      end
`endif
    end

    assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_busy[g]                          = busy;
  end

  assign a0 = regs[ADDR_WIDTH'(REG_A0)];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 2-port and a 4-port instance).
module tb_regfile_mp;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        issue_en;
  reg_idx_t    issue_rd;
  logic        wb0_en;
  reg_idx_t    wb0_rd;
  reg_data_t   wb0_data;
  logic        wb1_en;
  reg_idx_t    wb1_rd;
  reg_data_t   wb1_data;
  reg_data_t   a0;

  logic [19:0]  rd_addr4;
  logic [127:0] rd_data4;
  logic [3:0]   rd_busy4;
  reg_data_t    a0_4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .a0(a0)
  );

  regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4)) u_dut4 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_busy(rd_busy4),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .a0(a0_4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0; issue_rd = '0;
    wb0_en = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_en = 1'b0; wb1_rd = '0; wb1_data = '0;
  endtask

  task automatic wb0(input reg_idx_t r, input reg_data_t d);
    wb0_en = 1'b1; wb0_rd = r; wb0_data = d;
  endtask

  task automatic wb1(input reg_idx_t r, input reg_data_t d);
    wb1_en = 1'b1; wb1_rd = r; wb1_data = d;
  endtask

  task automatic issue(input reg_idx_t r);
    issue_en = 1'b1; issue_rd = r;
  endtask

  task automatic read2(input reg_idx_t p0, input reg_idx_t p1);
    rd_addr = {p1, p0};
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    rd_addr4 = '0;
    idle();
    tick();
    rst = 1'b0;

    // preload, then reset while other traffic is presented
    wb0(5'd5, 32'h1234);
    wb1(5'd10, 32'h77);
    issue(5'd6);
    tick();
    idle();
    read2(5'd5, 5'd6);
    check_eq("preload_x5", rd_data[31:0], 32'h1234);
    check_eq("preload_busy_x6", {31'd0, rd_busy[1]}, 32'd1);
    check_eq("preload_a0", a0, 32'h77);
    rst = 1'b1;
    issue(5'd5);
    wb0(5'd6, 32'hBEEF);
    tick();
    rst = 1'b0;
    idle();
    read2(5'd5, 5'd6);
    check_eq("rst_x5", rd_data[31:0], 32'h0);
    check_eq("rst_x6", rd_data[63:32], 32'h0);
    check_eq("rst_busy", {30'd0, rd_busy}, 32'd0);
    check_eq("rst_a0", a0, 32'h0);

    // x0 protection
    wb0(5'd0, 32'hFFFF_FFFF);
    wb1(5'd0, 32'hFFFF_FFFF);
    issue(5'd0);
    tick();
    idle();
    read2(5'd0, 5'd0);
    check_eq("x0_data", rd_data[31:0], 32'h0);
    check_eq("x0_busy", {31'd0, rd_busy[0]}, 32'd0);

    // dual write, distinct then colliding indices
    wb0(5'd3, 32'hAAAA);
    wb1(5'd4, 32'h5555);
    tick();
    idle();
    read2(5'd3, 5'd4);
    check_eq("dual_x3", rd_data[31:0], 32'hAAAA);
    check_eq("dual_x4", rd_data[63:32], 32'h5555);
    wb0(5'd7, 32'h1);
    wb1(5'd7, 32'h2);
    tick();
    idle();
    read2(5'd7, 5'd3);
    check_eq("collide_x7", rd_data[31:0], 32'h2);
    check_eq("collide_x3_kept", rd_data[63:32], 32'hAAAA);

    // scoreboard
    issue(5'd8);
    tick();
    idle();
    read2(5'd8, 5'd9);
    check_eq("sb_set_x8", {31'd0, rd_busy[0]}, 32'd1);
    check_eq("sb_idle_x9", {31'd0, rd_busy[1]}, 32'd0);
    wb1(5'd8, 32'h42);
    tick();
    idle();
    read2(5'd8, 5'd9);
    check_eq("sb_clr_x8", {31'd0, rd_busy[0]}, 32'd0);
    check_eq("sb_clr_data", rd_data[31:0], 32'h42);
    issue(5'd8);
    tick();
    issue(5'd8);
    wb0(5'd8, 32'h55);
    tick();
    idle();
    read2(5'd8, 5'd9);
    check_eq("sb_setwins_busy", {31'd0, rd_busy[0]}, 32'd1);
    check_eq("sb_setwins_data", rd_data[31:0], 32'h55);
    wb0(5'd9, 32'h11);
    tick();
    idle();
    read2(5'd8, 5'd9);
    check_eq("sb_other_kept", {31'd0, rd_busy[0]}, 32'd1);
    check_eq("sb_nonpend_busy", {31'd0, rd_busy[1]}, 32'd0);
    check_eq("sb_nonpend_data", rd_data[63:32], 32'h11);
    wb0(5'd8, 32'h66);
    tick();
    idle();
    read2(5'd8, 5'd9);
    check_eq("sb_wb0_clr", {31'd0, rd_busy[0]}, 32'd0);

    // same-cycle write-back visibility on x10 / a0
    wb0(5'd10, 32'h50);
    tick();
    idle();
    issue(5'd10);
    tick();
    idle();
    wb0(5'd10, 32'h99);
    read2(5'd0, 5'd10);
`ifdef REGFILE_BYPASS_EN
    check_eq("byp_data", rd_data[63:32], 32'h99);
    check_eq("byp_busy", {31'd0, rd_busy[1]}, 32'd0);
`else
    check_eq("nobyp_data", rd_data[63:32], 32'h50);
    check_eq("nobyp_busy", {31'd0, rd_busy[1]}, 32'd1);
`endif
    check_eq("byp_a0_old", a0, 32'h50);
    check_eq("byp_x0_port", rd_data[31:0], 32'h0);
    tick();
    idle();
    read2(5'd0, 5'd10);
    check_eq("byp_a0_new", a0, 32'h99);
    check_eq("byp_data_next", rd_data[63:32], 32'h99);
    check_eq("byp_busy_next", {31'd0, rd_busy[1]}, 32'd0);

    // issue alongside write-back keeps busy even with forwarding
    issue(5'd10);
    wb1(5'd10, 32'hAB);
    read2(5'd10, 5'd0);
`ifdef REGFILE_BYPASS_EN
    check_eq("byp_issue_data", rd_data[31:0], 32'hAB);
`else
    check_eq("nobyp_issue_data", rd_data[31:0], 32'h99);
`endif
    check_eq("byp_issue_busy", {31'd0, rd_busy[0]}, 32'd0);
    tick();
    idle();
    read2(5'd10, 5'd0);
    check_eq("issue_wb_busy", {31'd0, rd_busy[0]}, 32'd1);

    // four-port instance
    wb0(5'd1, 32'd1);
    wb1(5'd2, 32'd2);
    tick();
    idle();
    wb0(5'd3, 32'd3);
    wb1(5'd4, 32'd4);
    tick();
    idle();
    rd_addr4 = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    check_eq("p4_x1", rd_data4[31:0], 32'd1);
    check_eq("p4_x2", rd_data4[63:32], 32'd2);
    check_eq("p4_x3", rd_data4[95:64], 32'd3);
    check_eq("p4_x4", rd_data4[127:96], 32'd4);
    check_eq("p4_busy", {28'd0, rd_busy4}, 32'd0);
    check_eq("p4_a0", a0_4, 32'hAB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
